// File: rtl/core_mem_if.sv
// Processor-side bus of the multiport core memory: per-port request,
// address and data lanes packed into flat vectors, one busy line shared by all.
interface core_mem_if #(
    parameter int NPORT = 4,
    parameter int AW    = 14
);
    logic [NPORT-1:0]    rq_cyc;
    logic [NPORT-1:0]    rd_rq;
    logic [NPORT-1:0]    wr_rq;
    logic [NPORT-1:0]    wr_rs;
    logic [NPORT-1:0]    fmc_select;
    logic [NPORT*4-1:0]  sel;
    logic [NPORT*AW-1:0] ma;
    logic [NPORT*36-1:0] mb_in;
    logic [NPORT-1:0]    addr_ack;
    logic [NPORT-1:0]    rd_rs;
    logic [NPORT*36-1:0] mb_out;
    logic                busy;

    modport master (
        output rq_cyc, rd_rq, wr_rq, wr_rs, fmc_select, sel, ma, mb_in,
        input  addr_ack, rd_rs, mb_out, busy
    );

    modport slave (
        input  rq_cyc, rd_rq, wr_rq, wr_rs, fmc_select, sel, ma, mb_in,
        output addr_ack, rd_rs, mb_out, busy
    );
endinterface

// File: rtl/core_mem_nport.sv
// Multiport 36-bit core memory with round-robin arbitration and destructive-read/restore timing.
// Optional CORE_MEM_SINGLE_STEP_EN adds a STOP state held after each cycle until sw_restart rises.
module core_mem_nport #(
    parameter int                 NPORT  = 4,
    parameter int                 AW     = 14,
    parameter logic [NPORT*4-1:0] MEMSEL = '0,
    parameter int                 T_RD   = 20,
    parameter int                 T_WR   = 20,
    parameter int                 T_REC  = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef CORE_MEM_SINGLE_STEP_EN
    input  logic sw_single_step,
    input  logic sw_restart,
`endif
    core_mem_if.slave bus
);
    localparam int DATA_W = 36;
    localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TMAX   = (T_RD > T_WR) ? ((T_RD > T_REC) ? T_RD : T_REC)
                                          : ((T_WR > T_REC) ? T_WR : T_REC);
    localparam int CW     = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        IDLE, ACK, READ, RDRS, WAITWR, WRITE, REC
`ifdef CORE_MEM_SINGLE_STEP_EN
        , STOP
`endif
    } state_t;

    state_t                      state, state_n;
    logic [PW-1:0]               g, last_g, pick;
    logic [AW-1:0]               cma;
    logic                        rd_l, wr_l;
    logic signed [DATA_W-1:0]    cmb, sa;
    logic [CW-1:0]               cnt;
    logic [NPORT-1:0]            req;
    logic                        core_we;
    logic [NPORT-1:0]            ack_v, rs_v;
    logic [NPORT*DATA_W-1:0]     mbo;
    logic                        rd_done, wr_done, rec_done, restart;
    logic signed [DATA_W-1:0]    core [2**AW];

    always_comb begin
        req = '0;
        for (int i = 0; i < NPORT; i++)
            req[i] = bus.rq_cyc[i] & ~bus.fmc_select[i] & (bus.sel[4*i +: 4] == MEMSEL[4*i +: 4]);
    end

    // Nearest requester after last_g wins; scanning distances downward lets k=1 override.
    always_comb begin
        pick = last_g;
        for (int k = NPORT; k >= 1; k--)
            for (int i = 0; i < NPORT; i++)
                if (req[i] && ((int'(last_g) + k) % NPORT) == i) pick = PW'(i);
    end

    assign rd_done  = (cnt == CW'(T_RD - 1));
    assign wr_done  = (cnt == CW'(T_WR - 1));
    assign rec_done = (cnt == CW'(T_REC - 1));

`ifdef CORE_MEM_SINGLE_STEP_EN
    logic restart_q;
    always_ff @(posedge clk) begin
        if (reset) restart_q <= 1'b0;
        else       restart_q <= sw_restart;
    end
    assign restart = sw_restart & ~restart_q;
`else
    assign restart = 1'b0;
`endif

    always_comb begin
        state_n = state;
        core_we = 1'b0;
        ack_v   = '0;
        rs_v    = '0;
        mbo     = '0;
        case (state)
            IDLE:   if (|req) state_n = ACK;
            ACK: begin
                ack_v[g] = 1'b1;
                state_n  = READ;
            end
            READ:   if (rd_done) state_n = rd_l ? RDRS : (wr_l ? WAITWR : WRITE);
            RDRS: begin
                rs_v[g]                  = 1'b1;
                mbo[g*DATA_W +: DATA_W]  = sa;
                state_n                  = wr_l ? WAITWR : WRITE;
            end
            WAITWR: if (bus.wr_rs[g]) state_n = WRITE;
            WRITE: begin
                if (wr_done) begin
                    core_we = 1'b1;
                    state_n = REC;
                end
            end
            REC: begin
`ifdef CORE_MEM_SINGLE_STEP_EN
                if (rec_done) state_n = sw_single_step ? STOP : IDLE;
`else
                if (rec_done) state_n = IDLE;
`endif
            end
`ifdef CORE_MEM_SINGLE_STEP_EN
            STOP:   if (restart) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    assign bus.addr_ack = ack_v;
    assign bus.rd_rs    = rs_v;
    assign bus.mb_out   = mbo;
    assign bus.busy     = (state != IDLE);

    // Cycle state and datapath registers: cmb collects the word to be written back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            g      <= '0;
            last_g <= PW'(NPORT - 1);
            cma    <= '0;
            rd_l   <= 1'b0;
            wr_l   <= 1'b0;
            cmb    <= '0;
            sa     <= '0;
            cnt    <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n == state) ? cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        g      <= pick;
                        last_g <= pick;
                        cma    <= bus.ma[pick*AW +: AW];
                        rd_l   <= bus.rd_rq[pick];
                        wr_l   <= bus.wr_rq[pick];
                    end
                end
                ACK:    cmb <= '0;
                READ: begin
                    if (rd_done) begin
                        sa <= core[cma];
                        if (!rd_l && !wr_l) cmb <= core[cma];
                    end
                end
                RDRS:   cmb <= wr_l ? '0 : sa;
                WAITWR: cmb <= cmb | bus.mb_in[g*DATA_W +: DATA_W];
                default: ;
            endcase
        end
    end

    // Core array is not reset; a reset in the write-back cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (core_we && !reset) core[cma] <= cmb;
    end

    logic unused_ok;
    assign unused_ok = rec_done | restart;
endmodule

// File: doc/core_mem_nport.md
CORE_MEM_NPORT -- requirements
Module: core_mem_nport

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of processor ports (1..8).
REQ-002 SHALL have parameter AW, default 14, core address width (depth 2^AW words).
REQ-003 SHALL have parameter MEMSEL, default all-zero, NPORT*4 bits, 4-bit select jumper per port (port i at bits [4i+3:4i]).
REQ-004 SHALL have parameter T_RD, default 20, read-access cycles; T_WR, default 20, write cycles; T_REC, default 8, recovery cycles (each >=1).
REQ-005 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rq_cyc  in  NPORT  cycle request, level
- rd_rq  in  NPORT  read requested
- wr_rq  in  NPORT  write requested
- wr_rs  in  NPORT  write-restart, data valid on mb_in
- fmc_select  in  NPORT  fast-memory select, excludes this module
- sel  in  NPORT*4  memory select
- ma  in  NPORT*AW  address
- mb_in  in  NPORT*36  write data
- addr_ack  out  NPORT  one-cycle address acknowledge
- rd_rs  out  NPORT  one-cycle read restart
- mb_out  out  NPORT*36  read data, nonzero only at granted port
- busy  out  1  cycle in progress

Function
REQ-006 Port i SHALL request when rq_cyc[i] & ~fmc_select[i] & sel slice == MEMSEL slice.
REQ-007 FSM states SHALL be IDLE, ACK, READ, RDRS, WAITWR, WRITE, REC.
REQ-008 IDLE: if any request, SHALL grant by round-robin starting at (last granted + 1) mod NPORT, latch address, rd_rq, wr_rq of granted port, go ACK; last-granted resets to NPORT-1.
REQ-009 ACK: SHALL pulse addr_ack[g] one cycle, clear cmb, go READ.
REQ-010 READ: SHALL hold T_RD cycles, then load sa from core[cma]; go RDRS if rd_rq latched, else WAITWR if wr_rq latched, else WRITE.
REQ-011 RDRS: SHALL drive mb_out[g]=sa and rd_rs[g]=1 for exactly one cycle; if latched wr_rq, go WAITWR with cmb cleared, else go WRITE with cmb=sa (restore destructive read).
REQ-012 WAITWR: SHALL OR mb_in[g] into cmb each cycle; on wr_rs[g] high, SHALL include that cycle's mb_in then go WRITE; waits indefinitely.
REQ-013 WRITE: SHALL hold T_WR cycles, then write core[cma]=cmb, go REC.
REQ-014 REC: SHALL hold T_REC cycles then go IDLE; busy=1 in every state except IDLE.
REQ-015 Requests arriving mid-cycle SHALL wait; non-granted ports' outputs SHALL stay 0.
REQ-016 rq_cyc dropping after grant SHALL NOT abort the cycle.
REQ-017 Neither rd_rq nor wr_rq latched SHALL perform read-restore (READ->WRITE with cmb=sa).
REQ-018 Address width SHALL be AW bits, no wrap logic; mb_out zero whenever rd_rs low.

Reset
REQ-019 Reset SHALL force IDLE, all outputs 0, cmb=0, sa=0, counters 0, last-granted=NPORT-1; core contents unchanged.
REQ-020 Reset mid-cycle SHALL abandon the cycle without a core write.

Configuration
REQ-021 With CORE_MEM_SINGLE_STEP_EN defined, SHALL add inputs sw_single_step and sw_restart; when sw_single_step=1 at REC exit, SHALL enter STOP (busy=1, no grants) until sw_restart rising edge, then IDLE.
REQ-022 Without CORE_MEM_SINGLE_STEP_EN, SHALL have no such ports or STOP state.

Verification
REQ-023 Port 0 write-only 0o123456701234 to addr 0o17, wr_rs 3 cycles after ack -> core[0o17]=0o123456701234, one addr_ack[0], no rd_rs.
REQ-024 Port 1 read addr 0o17 -> rd_rs[1] one cycle, mb_out[1]=0o123456701234, core unchanged after REC.
REQ-025 Ports 2 and 3 requesting together twice after last grant 2 -> order 3 then 2.
REQ-026 Read-modify-write port 0 addr 5 holding 7, write 0o10 -> rd_rs data 7, core[5]=0o10.
REQ-027 Reset asserted during WAITWR -> IDLE next cycle, core[addr] unchanged, all outputs 0.
REQ-028 Single-step build: sw_single_step=1 -> busy stays 1 after REC until sw_restart edge, then next grant.
